// File: rtl/uop_seq_ctrl.sv
// uop_seq_ctrl: microcode sequencer for curve-arithmetic ROMs; optional WAITOP watchdog via UOP_SEQ_WATCHDOG_EN
module uop_seq_ctrl #(
    parameter int         ADDR_W = 6,
    parameter int         WDOG_W = 12,
    parameter logic [4:0] PZ_IDX = 5'd8,
    parameter logic [4:0] T1_IDX = 5'd9,
    parameter logic [4:0] T2_IDX = 5'd10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [19:0]       rom_data,
    output logic              op_ena,
    output logic [3:0]        op_code,
    output logic [4:0]        op_src1,
    output logic [4:0]        op_src2,
    output logic [3:0]        op_dst,
    input  logic              op_rdy,
    input  logic              cmp_zero,
    output logic [2:0]        flags,
    output logic              err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ROMWAIT = 3'd2;
    localparam logic [2:0] S_DECODE  = 3'd3;
    localparam logic [2:0] S_ISSUE   = 3'd4;
    localparam logic [2:0] S_WAITOP  = 3'd5;
    localparam logic [2:0] S_END     = 3'd6;
    localparam logic [3:0] OP_CMP    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [ADDR_W-1:0] AONE = 1;

    logic [2:0] state;
    logic [3:0] d_op;
    logic [1:0] d_ex;
    logic       d_rdy;
    logic       d_go;
    logic       last;
    logic       wdog_to;

    assign d_op   = rom_data[19:16];
    assign d_ex   = rom_data[1:0];
    assign d_rdy  = (d_op == 4'd0) || (d_op > OP_MUL);
    assign d_go   = (d_ex == 2'd0) ? 1'b1 :
                    (d_ex == 2'd1) ? !flags[2] :
                    (d_ex == 2'd2) ? (flags == 3'b100) : (flags == 3'b101);
    assign last   = &rom_addr;
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_END);
    assign op_ena = (state == S_ISSUE);

`ifdef UOP_SEQ_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WONE = 1;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_nxt;
    logic              err_q;
    assign wdog_nxt = wdog + WONE;
    assign wdog_to  = &wdog_nxt;
    assign err      = err_q;
    // Watchdog restarts on every entry to WAITOP; err sticks until the next accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog <= (state == S_WAITOP) ? wdog_nxt : '0;
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (state == S_WAITOP && !op_rdy && wdog_to)
                err_q <= 1'b1;
        end
    end
`else
    assign wdog_to = (WDOG_W == 0);
    assign err     = 1'b0;
`endif

    // Sequencer FSM: fetch, decode/condition check, issue, await completion; no wrap past the top address
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            flags    <= 3'b000;
            op_code  <= 4'd0;
            op_src1  <= 5'd0;
            op_src2  <= 5'd0;
            op_dst   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rom_addr <= base_addr;
                    flags    <= 3'b000;
                    state    <= S_FETCH;
                end
                S_FETCH:   state <= S_ROMWAIT;
                S_ROMWAIT: state <= S_DECODE;
                S_DECODE: if (d_rdy) begin
                    state <= S_END;
                end else if (d_go) begin
                    op_code <= d_op;
                    op_src1 <= rom_data[15:11];
                    op_src2 <= rom_data[10:6];
                    op_dst  <= rom_data[5:2];
                    state   <= S_ISSUE;
                end else begin
                    rom_addr <= last ? rom_addr : rom_addr + AONE;
                    state    <= last ? S_END : S_FETCH;
                end
                S_ISSUE: state <= S_WAITOP;
                S_WAITOP: if (op_rdy) begin
                    if (op_code == OP_CMP && op_src1 == PZ_IDX) flags[2] <= !cmp_zero;
                    if (op_code == OP_CMP && op_src1 == T1_IDX) flags[1] <= !cmp_zero;
                    if (op_code == OP_CMP && op_src1 == T2_IDX) flags[0] <= !cmp_zero;
                    rom_addr <= last ? rom_addr : rom_addr + AONE;
                    state    <= last ? S_END : S_FETCH;
                end else if (wdog_to) begin
                    state <= S_END;
                end
                S_END:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
